// File: rtl/reuleaux_pkg.sv
// Shared types and constants for the Reuleaux triangle sequencer.
package reuleaux_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_CALC,
    ST_ARC_RUN,
    ST_ARC_GAP,
    ST_DONE
  } state_e;

  typedef logic signed [9:0] coord_t;

  localparam int SCREEN_W   = 160;
  localparam int SCREEN_H   = 120;
  localparam int SQRT3_6_Q8 = 74;
  localparam int SQRT3_3_Q8 = 148;
  localparam int CLIP_MIN   = -512;
  localparam int CLIP_MAX   = 511;

  // Unsigned Q8 scaling of an 8-bit length; the result always fits in 8 bits.
  function automatic coord_t q8_scale(input logic [7:0] len, input logic [7:0] k);
    logic [15:0] prod;
    prod = {8'd0, len} * {8'd0, k};
    return coord_t'({2'b00, prod[15:8]});
  endfunction

endpackage

// File: rtl/fill_screen.sv
// Raster pixel counter for the full-screen clear: y outer, x inner.
module fill_screen
  import reuleaux_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  output logic [7:0] x_o,
  output logic [6:0] y_o,
  output logic       plot_o,
  output logic       done_o
);

  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic       last;

  assign last = (x_q == 8'(SCREEN_W - 1)) && (y_q == 7'(SCREEN_H - 1));

  // Counters wrap back to (0,0) after the last pixel so the next pass starts clean.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (start_i) begin
      if (x_q == 8'(SCREEN_W - 1)) begin
        x_d = 8'd0;
        y_d = (y_q == 7'(SCREEN_H - 1)) ? 7'd0 : y_q + 7'd1;
      end else begin
        x_d = x_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= 8'd0;
      y_q <= 7'd0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign plot_o = start_i;
  assign done_o = start_i && last;

endmodule

// File: rtl/reuleaux_ctrl.sv
// Sequences an optional screen clear and three clipped arcs that form a
// Reuleaux triangle, muxing clear and drawer pixels onto one VGA port.
module reuleaux_ctrl
  import reuleaux_pkg::*;
#(
  parameter bit         CLEAR_EN  = 1'b1,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         colour,
  input  logic [7:0]         centre_x,
  input  logic [6:0]         centre_y,
  input  logic [7:0]         diameter,
  output logic               done,
  output logic               circ_start,
  input  logic               circ_done,
  output logic signed [9:0]  circ_cx,
  output logic signed [9:0]  circ_cy,
  output logic [7:0]         circ_radius,
  output logic [2:0]         circ_colour,
  output logic signed [9:0]  clip_xmin,
  output logic signed [9:0]  clip_xmax,
  output logic signed [9:0]  clip_ymin,
  output logic signed [9:0]  clip_ymax,
  input  logic [7:0]         circ_vga_x,
  input  logic [6:0]         circ_vga_y,
  input  logic [2:0]         circ_vga_colour,
  input  logic               circ_vga_plot,
  output logic [7:0]         vga_x,
  output logic [6:0]         vga_y,
  output logic [2:0]         vga_colour,
  output logic               vga_plot
);

  state_e     state_q, state_d;
  logic [7:0] cx_q, cx_d, dia_q, dia_d;
  logic [6:0] cy_q, cy_d;
  logic [2:0] col_q, col_d;
  logic [1:0] idx_q, idx_d;
  coord_t     ty_q, ty_d, lx_q, lx_d, rx_q, rx_d, by_q, by_d;

  logic       fs_start, fs_plot, fs_done;
  logic [7:0] fs_x;
  logic [6:0] fs_y;

  coord_t cx_s, cy_s, half, h, v;
  coord_t a_cx, a_cy, a_xmin, a_xmax, a_ymin, a_ymax;

  assign fs_start = (state_q == ST_CLEAR);

  fill_screen u_fill (
    .clk     (clk),
    .rst     (rst),
    .start_i (fs_start),
    .x_o     (fs_x),
    .y_o     (fs_y),
    .plot_o  (fs_plot),
    .done_o  (fs_done)
  );

  assign cx_s = coord_t'({2'b00, cx_q});
  assign cy_s = coord_t'({3'b000, cy_q});
  assign half = coord_t'({3'b000, dia_q[7:1]});
  assign h    = q8_scale(dia_q, 8'(SQRT3_6_Q8));
  assign v    = q8_scale(dia_q, 8'(SQRT3_3_Q8));

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    dia_d   = dia_q;
    col_d   = col_q;
    idx_d   = idx_q;
    ty_d    = ty_q;
    lx_d    = lx_q;
    rx_d    = rx_q;
    by_d    = by_q;
    case (state_q)
      ST_IDLE: begin
        idx_d = 2'd0;
        if (start) begin
          cx_d    = centre_x;
          cy_d    = centre_y;
          dia_d   = diameter;
          col_d   = colour;
          state_d = CLEAR_EN ? ST_CLEAR : ST_CALC;
        end
      end
      ST_CLEAR:   if (fs_done) state_d = ST_CALC;
      ST_CALC: begin
        ty_d    = cy_s - v;
        lx_d    = cx_s - half;
        rx_d    = cx_s + half;
        by_d    = cy_s + h;
        state_d = ST_ARC_RUN;
      end
      ST_ARC_RUN: if (circ_done) state_d = ST_ARC_GAP;
      ST_ARC_GAP: begin
        if (!circ_done) begin
          if (idx_q == 2'd2) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_ARC_RUN;
          end
        end
      end
      ST_DONE:    if (!start) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Arc table: centre at one vertex, clipped to the sector facing the opposite edge.
  always_comb begin
    a_cx   = cx_s;
    a_cy   = ty_q;
    a_xmin = lx_q;
    a_xmax = rx_q;
    a_ymin = by_q;
    a_ymax = coord_t'(CLIP_MAX);
    case (idx_q)
      2'd1: begin
        a_cx   = lx_q;
        a_cy   = by_q;
        a_xmin = cx_s;
        a_xmax = coord_t'(CLIP_MAX);
        a_ymin = ty_q;
        a_ymax = by_q;
      end
      2'd2: begin
        a_cx   = rx_q;
        a_cy   = by_q;
        a_xmin = coord_t'(CLIP_MIN);
        a_xmax = cx_s;
        a_ymin = ty_q;
        a_ymax = by_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    done       = 1'b0;
    circ_start = 1'b0;
    circ_cx    = '0;
    circ_cy    = '0;
    clip_xmin  = '0;
    clip_xmax  = '0;
    clip_ymin  = '0;
    clip_ymax  = '0;
    vga_x      = 8'd0;
    vga_y      = 7'd0;
    vga_colour = 3'd0;
    vga_plot   = 1'b0;
    if (state_q == ST_ARC_RUN || state_q == ST_ARC_GAP) begin
      circ_cx   = a_cx;
      circ_cy   = a_cy;
      clip_xmin = a_xmin;
      clip_xmax = a_xmax;
      clip_ymin = a_ymin;
      clip_ymax = a_ymax;
    end
    case (state_q)
      ST_CLEAR: begin
        vga_x      = fs_x;
        vga_y      = fs_y;
        vga_colour = BG_COLOUR;
        vga_plot   = fs_plot;
      end
      ST_ARC_RUN: begin
        circ_start = 1'b1;
        vga_x      = circ_vga_x;
        vga_y      = circ_vga_y;
        vga_colour = circ_vga_colour;
        vga_plot   = circ_vga_plot;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign circ_radius = dia_q;
  assign circ_colour = col_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cx_q    <= 8'd0;
      cy_q    <= 7'd0;
      dia_q   <= 8'd0;
      col_q   <= 3'd0;
      idx_q   <= 2'd0;
      ty_q    <= '0;
      lx_q    <= '0;
      rx_q    <= '0;
      by_q    <= '0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      dia_q   <= dia_d;
      col_q   <= col_d;
      idx_q   <= idx_d;
      ty_q    <= ty_d;
      lx_q    <= lx_d;
      rx_q    <= rx_d;
      by_q    <= by_d;
    end
  end

endmodule

// File: tb/tb_reuleaux_ctrl.sv
// Scoreboard bench for reuleaux_ctrl: stimulus and a drawer responder push
// expectations, a separate monitor pops and compares what the DUT presents.
module tb_reuleaux_ctrl;

  localparam logic [2:0] BG = 3'b101;

  logic clk = 1'b0;
  logic rst, start, done, circ_start, circ_done;
  logic [2:0] colour, circ_colour, circ_vga_colour, vga_colour;
  logic [7:0] centre_x, diameter, circ_radius, circ_vga_x, vga_x;
  logic [6:0] centre_y, circ_vga_y, vga_y;
  logic signed [9:0] circ_cx, circ_cy, clip_xmin, clip_xmax, clip_ymin, clip_ymax;
  logic circ_vga_plot, vga_plot;
  logic [70:0] dut_geo;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct { int cyc; logic [7:0] x; logic [6:0] y; logic [2:0] c; } pix_t;
  typedef struct { int idx; int cyc; logic [70:0] geo; } arc_t;

  pix_t exp_pix[$];
  arc_t exp_arc[$];

  reuleaux_ctrl #(.CLEAR_EN(1'b1), .BG_COLOUR(BG)) dut (
    .clk(clk), .rst(rst), .start(start), .colour(colour),
    .centre_x(centre_x), .centre_y(centre_y), .diameter(diameter),
    .done(done), .circ_start(circ_start), .circ_done(circ_done),
    .circ_cx(circ_cx), .circ_cy(circ_cy), .circ_radius(circ_radius),
    .circ_colour(circ_colour), .clip_xmin(clip_xmin), .clip_xmax(clip_xmax),
    .clip_ymin(clip_ymin), .clip_ymax(clip_ymax),
    .circ_vga_x(circ_vga_x), .circ_vga_y(circ_vga_y),
    .circ_vga_colour(circ_vga_colour), .circ_vga_plot(circ_vga_plot),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  assign dut_geo = {circ_cx, circ_cy, clip_xmin, clip_xmax, clip_ymin, clip_ymax,
                    circ_radius, circ_colour};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  function automatic logic [70:0] pk(input int a, input int b, input int c, input int e,
                                     input int f, input int g, input int r, input int col);
    return {10'(a), 10'(b), 10'(c), 10'(e), 10'(f), 10'(g), 8'(r), 3'(col)};
  endfunction

  // Reference: vertices from the triangle geometry, then the three arcs.
  task automatic issue(input int cx, input int cy, input int d, input int col,
                       input int nclear, input bit arcs);
    int c0, h, v, ty, lx, rx, by;
    @(negedge clk);
    centre_x = 8'(cx);
    centre_y = 7'(cy);
    diameter = 8'(d);
    colour   = 3'(col);
    start    = 1'b1;
    c0       = cyc;
    for (int i = 0; i < nclear; i++)
      exp_pix.push_back('{cyc: c0 + 1 + i, x: 8'(i % 160), y: 7'(i / 160), c: BG});
    if (arcs) begin
      h  = (d * 74) / 256;
      v  = (d * 148) / 256;
      ty = cy - v;
      lx = cx - d / 2;
      rx = cx + d / 2;
      by = cy + h;
      exp_arc.push_back('{idx: 0, cyc: c0 + 19202, geo: pk(cx, ty, lx, rx, by, 511, d, col)});
      exp_arc.push_back('{idx: 1, cyc: 0, geo: pk(lx, by, cx, 511, ty, by, d, col)});
      exp_arc.push_back('{idx: 2, cyc: 0, geo: pk(rx, by, -512, cx, ty, by, d, col)});
    end
  endtask

  task automatic run(input int cx, input int cy, input int d);
    issue(cx, cy, d, int'($urandom_range(0, 7)), 19200, 1'b1);
    @(negedge clk);
    centre_x = 8'($urandom);
    centre_y = 7'($urandom);
    diameter = 8'($urandom);
    colour   = 3'($urandom);
    repeat (100) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 25000 && !done; k++) @(negedge clk);
    chk("done_reached", 128'(done), 128'(1'b1));
    repeat ($urandom_range(2, 6)) @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Stimulus
  initial begin
    rst = 1'b1; start = 1'b0; colour = 3'd0;
    centre_x = 8'd0; centre_y = 7'd0; diameter = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    issue(80, 60, 80, int'($urandom_range(0, 7)), 837, 1'b0);
    repeat (838) @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_pix_left", 128'(exp_pix.size()), 128'(0));
    run(80, 60, 80);
    run(10, 5, 200);
    run(int'($urandom_range(0, 159)), int'($urandom_range(0, 119)), int'($urandom_range(1, 255)));
    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Drawer responder: random run length and done-hold, junk pixels whenever idle.
  initial begin
    int phase, nrun, hold;
    phase = 0; nrun = 0; hold = 0;
    circ_done = 1'b0;
    circ_vga_x = 8'd0; circ_vga_y = 7'd0; circ_vga_colour = 3'd0; circ_vga_plot = 1'b0;
    forever begin
      @(negedge clk);
      circ_vga_x      = 8'($urandom);
      circ_vga_y      = 7'($urandom);
      circ_vga_colour = 3'($urandom);
      circ_vga_plot   = 1'b1;
      if (rst) begin
        phase = 0;
        circ_done = 1'b0;
      end else begin
        case (phase)
          0: if (circ_start) begin nrun = int'($urandom_range(1, 5)); phase = 1; end
          1: if (!circ_start) begin phase = 2; hold = int'($urandom_range(1, 4)); end
          default: if (hold <= 1) begin circ_done = 1'b0; phase = 0; end else hold--;
        endcase
        if (phase == 1 && circ_start) begin
          circ_vga_plot = 1'($urandom_range(0, 1));
          if (circ_vga_plot)
            exp_pix.push_back('{cyc: cyc, x: circ_vga_x, y: circ_vga_y, c: circ_vga_colour});
          if (nrun == 0) circ_done = 1'b1;
          else nrun--;
        end
      end
    end
  end

  // Monitor
  initial begin
    arc_t cur;
    pix_t e;
    int rise_exp, done_exp;
    logic p_start, p_done, p_cs, p_cd;
    cur = '{idx: 0, cyc: 0, geo: '0};
    rise_exp = -1; done_exp = -1;
    p_start = 1'b0; p_done = 1'b0; p_cs = 1'b0; p_cd = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        chk("reset_outputs", 128'({done, circ_start, vga_plot, vga_x, vga_y, vga_colour, dut_geo}),
            128'(0));
        rise_exp = -1;
        done_exp = -1;
      end else begin
        if (vga_plot) begin
          if (exp_pix.size() == 0) begin
            chk("unexpected_plot", 128'(vga_plot), 128'(1'b0));
          end else begin
            e = exp_pix.pop_front();
            chk("pixel", 128'({cyc, vga_x, vga_y, vga_colour}), 128'({e.cyc, e.x, e.y, e.c}));
          end
        end else if (!circ_start) begin
          chk("idle_vga_zero", 128'({vga_x, vga_y, vga_colour}), 128'(0));
        end
        if (circ_start && !p_cs) begin
          chk("start_while_done", 128'(circ_done), 128'(1'b0));
          if (exp_arc.size() == 0) begin
            chk("extra_arc", 128'(circ_start), 128'(1'b0));
          end else begin
            cur = exp_arc.pop_front();
            if (cur.idx != 0) cur.cyc = rise_exp;
            chk("arc_start", 128'({cyc, dut_geo}), 128'({cur.cyc, cur.geo}));
          end
        end
        if (!circ_start && p_cs) chk("arc_geo_gap_entry", 128'(dut_geo), 128'(cur.geo));
        if (!circ_done && p_cd) begin
          if (!circ_start) chk("arc_geo_gap_exit", 128'(dut_geo), 128'(cur.geo));
          if (cur.idx == 2) done_exp = cyc + 1;
          else rise_exp = cyc + 1;
        end
        if (done && !p_done) begin
          chk("done_cycle", 128'(cyc), 128'(done_exp));
          chk("arcs_left", 128'(exp_arc.size()), 128'(0));
          chk("pix_left", 128'(exp_pix.size()), 128'(0));
          done_exp = -1;
        end
        if (p_done) chk("done_hold", 128'(done), 128'(p_start));
      end
      p_start = start;
      p_done  = done;
      p_cs    = circ_start;
      p_cd    = circ_done;
    end
  end

endmodule

// File: doc/reuleaux_ctrl.md
# reuleaux_ctrl

Upstream sequencer for the clipped-circle drawer. On `start` it optionally clears the 160×120 screen, then computes the three vertices of a Reuleaux triangle from a centre and diameter. It runs the circle drawer three times (one arc per vertex) with the correct centre, radius and clip window, and muxes the clear-pixel stream and the drawer's pixel stream onto the single VGA write port.

## Interface
- `CLEAR_EN`, default 1: when 1, a full-screen clear precedes drawing.
- `BG_COLOUR`, default 3'b000: colour used by the clear pass.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  level request; held high until `done`.
- `colour`  in  3  triangle colour, passed to the drawer.
- `centre_x`  in  8  triangle centre x.
- `centre_y`  in  7  triangle centre y.
- `diameter`  in  8  triangle width (arc radius).
- `done`  out  1  high in DONE until `start` drops.
- `circ_start`  out  1  drawer request, level.
- `circ_done`  in  1  drawer completion, level.
- `circ_cx`, `circ_cy`  out  10 signed  arc centre.
- `circ_radius`  out  8  equals `diameter`.
- `circ_colour`  out  3  equals `colour`.
- `clip_xmin`, `clip_xmax`, `clip_ymin`, `clip_ymax`  out  10 signed  inclusive clip box for the current arc.
- `circ_vga_x` (8), `circ_vga_y` (7), `circ_vga_colour` (3), `circ_vga_plot` (1)  in  drawer pixel stream.
- `vga_x` (8), `vga_y` (7), `vga_colour` (3), `vga_plot` (1)  out  to VGA adapter.

## Operation
- **States:** IDLE, CLEAR, CALC, ARC_RUN, ARC_GAP, DONE.
- **IDLE:**
  - Inputs are latched when `start`=1.
  - The next state is CLEAR when `CLEAR_EN`=1, otherwise CALC.
- **CLEAR:**
  - Pixel counter with y outer 0..119 and x inner 0..159.
  - Outputs `vga_plot`=1, `vga_colour`=`BG_COLOUR`, `vga_x/y`=counter.
  - After (159,119) the state moves to CALC.
- **CALC:** one cycle; registers the vertices in signed 10-bit arithmetic.
  - h = (d·74)>>8 and v = (d·148)>>8. These are Q8 approximations of √3/6 and √3/3.
  - T = (cx, cy−v).
  - L = (cx−(d>>1), cy+h).
  - R = (cx+(d>>1), cy+h).
- **Arc table** (index 0,1,2, in this order):
  - Arc 0: centre T; clip x∈[Lx,Rx], y∈[Ly,511].
  - Arc 1: centre L; clip x∈[cx,511], y∈[Ty,Ly].
  - Arc 2: centre R; clip x∈[−512,cx], y∈[Ty,Ly].
- **ARC_RUN:**
  - `circ_start`=1.
  - VGA outputs pass through the `circ_vga_*` inputs combinationally.
  - On `circ_done`=1 the state moves to ARC_GAP.
- **ARC_GAP:**
  - `circ_start`=0 and `vga_plot`=0.
  - Stays until `circ_done`=0, with a minimum of 1 cycle.
  - Then the index increments and the state returns to ARC_RUN. After index 2 the state moves to DONE.
- **DONE:** `done`=1; when `start`=0 the state returns to IDLE.
- **Outside CLEAR/ARC_RUN:** `vga_plot`=0 and `vga_x/y/colour`=0.
- **Input stability:** `start` dropping before DONE is ignored. Input changes after the IDLE latch are ignored.
- **Off-screen values:** vertices and clip bounds may be negative or off-screen. Screen clipping is the drawer's job.

## Timing
- **Reset:** asynchronous. State goes to IDLE, the counters and arc index to 0.
- **Reset values:** `done`=0, `circ_start`=0, `vga_plot`=0, all data outputs 0.
- **Reset mid-operation:** aborts immediately. No further `vga_plot` until a new `start`.
- **Clear pass:**
  - First clear pixel (0,0) appears the cycle after `start` is sampled in IDLE.
  - Exactly 19200 consecutive plot cycles.
- **CALC** occupies exactly 1 cycle. `circ_start` rises the following cycle.
- **Clip/centre outputs** are stable for the whole of ARC_RUN and ARC_GAP.
- **`done`** rises the cycle after ARC_GAP of arc 2 sees `circ_done`=0.
- **Minimum latency with `CLEAR_EN`=0:** IDLE→CALC→ARC_RUN, i.e. `circ_start` is high 2 cycles after `start` is sampled.

## Structure
- **Package `reuleaux_pkg`:**
  - State enum.
  - `SCREEN_W`=160, `SCREEN_H`=120.
  - `SQRT3_6_Q8`=74, `SQRT3_3_Q8`=148.
  - `CLIP_MIN`=−512, `CLIP_MAX`=511.
- **Sub-module `fill_screen`:**
  - start/done handshake plus x/y counter. Emits the clear pixels and asserts done on the last pixel.
  - Instantiated once; its output is muxed by `reuleaux_ctrl`.

## Test plan
- **Reset:** assert `rst` mid-CLEAR at pixel (37,5) -> `vga_plot`=0 that cycle, state IDLE, all outputs 0, no plot until next `start`.
- **Clear:** `CLEAR_EN`=1, `start`=1 -> exactly 19200 plots of `BG_COLOUR`, raster order, first (0,0), last (159,119), no gaps or duplicates.
- **Geometry:** cx=80, cy=60, d=80 -> arc 0 centre (80,14), clip x[40,120] y[83,511].
  - Arc 1: centre (40,83), clip x[80,511] y[14,83].
  - Arc 2: centre (120,83), clip x[−512,80] y[14,83].
  - `circ_radius`=80 throughout.
- **Off-screen vertices:** cx=10, cy=5, d=200.
  - h=57 and v=115.
  - Expected T=(10,−110), L=(−90,62), R=(110,62), with signed values correct.
- **Handshake:** drawer model holds `circ_done` 3 cycles after `circ_start` drops.
  - `circ_start` stays 0 until `circ_done`=0.
  - Exactly three `circ_start` rising edges.
  - Drawer pixels are forwarded only in ARC_RUN.
- **Completion:** hold `start`=1 -> `done` stays 1. Drop `start` -> IDLE next cycle, `done`=0. Reassert `start` -> the full sequence repeats.
